// File: rtl/cyl_to_sph_cordic_if.sv
// Handshake bundle for cyl_to_sph_cordic: input sample (r, theta, z) and
// output result (rho, theta, phi[, sat_flag]); slave = converter, master = neighbours.
interface cyl_to_sph_cordic_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r_in;
  logic [7:0] theta_in;
  logic [7:0] z_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rho_out;
  logic [7:0] theta_out;
  logic [7:0] phi_out;
`ifdef CYL_SPH_SAT_FLAG_EN
  logic       sat_flag;
`endif

  modport slave (
    input  in_valid, r_in, theta_in, z_in, out_ready,
    output in_ready, out_valid, rho_out, theta_out, phi_out
`ifdef CYL_SPH_SAT_FLAG_EN
    , output sat_flag
`endif
  );

  modport master (
    output in_valid, r_in, theta_in, z_in, out_ready,
    input  in_ready, out_valid, rho_out, theta_out, phi_out
`ifdef CYL_SPH_SAT_FLAG_EN
    , input sat_flag
`endif
  );
endinterface

// File: rtl/cyl_to_sph_cordic.sv
// Cylindrical (r,theta,z) -> spherical (rho,theta,phi) via iterative CORDIC vectoring.
// Ports: clk, rst_n (async low), ena (clock enable), bus (slave: in/out valid-ready
// handshakes, r/theta/z in, rho/theta/phi out). Macro CYL_SPH_SAT_FLAG_EN adds sat_flag.
module cyl_to_sph_cordic #(
  parameter int ITER = 8,
  parameter int FRAC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  cyl_to_sph_cordic_if.slave  bus
);
  localparam int W = 11 + FRAC;

  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_e;

  state_e                state_q, state_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   y_q, y_d;
  logic signed [9:0]     ang_q, ang_d;
  logic [3:0]            i_q, i_d;
  logic                  byp_q, byp_d;
  logic                  live_q;
  logic [7:0]            rho_q, rho_d;
  logic [7:0]            th_q, th_d;
  logic [7:0]            phi_q, phi_d;
`ifdef CYL_SPH_SAT_FLAG_EN
  logic                  sat_q, sat_d;
`endif

  logic                  acc;
  logic signed [W-1:0]   xs, ys, kx;

  function automatic logic signed [9:0] atan_t(input logic [3:0] idx);
    case (idx)
      4'd0:    return 10'sd128;
      4'd1:    return 10'sd76;
      4'd2:    return 10'sd40;
      4'd3:    return 10'sd20;
      4'd4:    return 10'sd10;
      4'd5:    return 10'sd5;
      4'd6:    return 10'sd3;
      4'd7:    return 10'sd1;
      4'd8:    return 10'sd1;
      default: return 10'sd0;
    endcase
  endfunction

  // live_q keeps in_ready low during the reset cycle
  assign acc = ena & bus.in_valid & live_q & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (acc) state_d = (bus.r_in == 8'd0) ? SCALE : ROTATE;
      ROTATE: if (i_q == 4'(ITER - 1)) state_d = SCALE;
      SCALE:  state_d = DONE;
      DONE:   if (bus.out_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = live_q & (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.rho_out   = rho_q;
  assign bus.theta_out = th_q;
  assign bus.phi_out   = phi_q;
`ifdef CYL_SPH_SAT_FLAG_EN
  assign bus.sat_flag  = sat_q;
`endif

  // gain compensation: 1/1.6468 ~ 1/2 + 1/8 - 1/64 - 1/512
  assign xs = x_q >>> i_q;
  assign ys = y_q >>> i_q;
  assign kx = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ang_d = ang_q;
    i_d   = i_q;
    byp_d = byp_q;
    rho_d = rho_q;
    th_d  = th_q;
    phi_d = phi_q;
`ifdef CYL_SPH_SAT_FLAG_EN
    sat_d = sat_q;
`endif
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            x_d   = {{(W-8-FRAC){1'b0}}, bus.z_in, {FRAC{1'b0}}};
            y_d   = {{(W-8-FRAC){1'b0}}, bus.r_in, {FRAC{1'b0}}};
            ang_d = '0;
            i_d   = '0;
            th_d  = bus.theta_in;
            byp_d = (bus.r_in == 8'd0);
          end
        end
        ROTATE: begin
          if (!y_q[W-1]) begin
            x_d   = x_q + ys;
            y_d   = y_q - xs;
            ang_d = ang_q + atan_t(i_q);
          end else begin
            x_d   = x_q - ys;
            y_d   = y_q + xs;
            ang_d = ang_q - atan_t(i_q);
          end
          i_d = i_q + 4'd1;
        end
        SCALE: begin
          if (byp_q) begin
            // r==0: rho is z itself, no gain to undo
            rho_d = x_q[FRAC+7:FRAC];
            phi_d = 8'd0;
`ifdef CYL_SPH_SAT_FLAG_EN
            sat_d = 1'b0;
`endif
          end else begin
            if (kx[W-1]) begin
              rho_d = 8'd0;
`ifdef CYL_SPH_SAT_FLAG_EN
              sat_d = 1'b0;
`endif
            end else if (|kx[W-2:FRAC+8]) begin
              rho_d = 8'hFF;
`ifdef CYL_SPH_SAT_FLAG_EN
              sat_d = 1'b1;
`endif
            end else begin
              rho_d = kx[FRAC+7:FRAC];
`ifdef CYL_SPH_SAT_FLAG_EN
              sat_d = 1'b0;
`endif
            end
            phi_d = ang_q[9] ? 8'd0 :
                    ang_q[8] ? 8'hFF : ang_q[7:0];
          end
        end
        DONE: begin
`ifdef CYL_SPH_SAT_FLAG_EN
          if (bus.out_ready) sat_d = 1'b0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      ang_q <= '0;
      i_q   <= '0;
      byp_q <= 1'b0;
      rho_q <= '0;
      th_q  <= '0;
      phi_q <= '0;
`ifdef CYL_SPH_SAT_FLAG_EN
      sat_q <= 1'b0;
`endif
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      ang_q <= ang_d;
      i_q   <= i_d;
      byp_q <= byp_d;
      rho_q <= rho_d;
      th_q  <= th_d;
      phi_q <= phi_d;
`ifdef CYL_SPH_SAT_FLAG_EN
      sat_q <= sat_d;
`endif
    end
  end
endmodule

// File: tb/tb_cyl_to_sph_cordic.sv
// Directed bench for cyl_to_sph_cordic: hand-worked CORDIC vectors,
// bypass, saturation, backpressure, mid-op reset and enable stalls.
module tb_cyl_to_sph_cordic;
  localparam int ITER = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   lat;

  cyl_to_sph_cordic_if bus ();

  cyl_to_sph_cordic #(.ITER(ITER), .FRAC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] z,
                      input logic [7:0] th, input bit tog,
                      output int l);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.r_in     = r;
    bus.z_in     = z;
    bus.theta_in = th;
    tick();
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 100) begin
      if (tog) ena = (l % 2 == 1);
      tick();
      l++;
    end
    ena = 1'b1;
    chk("out_valid", int'(bus.out_valid), 1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pop", int'(bus.out_valid), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.r_in      = '0;
    bus.z_in      = '0;
    bus.theta_in  = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst in_ready", int'(bus.in_ready), 0);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst rho", int'(bus.rho_out), 0);
    chk("rst phi", int'(bus.phi_out), 0);
    chk("rst theta", int'(bus.theta_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", int'(bus.in_ready), 1);

    send(8'd10, 8'd10, 8'd7, 1'b0, lat);
    chk("10,10 lat", lat, ITER + 2);
    chk("10,10 rho", int'(bus.rho_out), 14);
    chk("10,10 phi", int'(bus.phi_out), 127);
    chk("10,10 theta", int'(bus.theta_out), 7);
`ifdef CYL_SPH_SAT_FLAG_EN
    chk("10,10 sat", int'(bus.sat_flag), 0);
`endif
    pop();

    send(8'd3, 8'd4, 8'h55, 1'b0, lat);
    chk("3,4 rho", int'(bus.rho_out), 5);
    chk("3,4 phi", int'(bus.phi_out), 105);
    chk("3,4 theta", int'(bus.theta_out), 8'h55);
    pop();

    send(8'd0, 8'd5, 8'd1, 1'b0, lat);
    chk("0,5 lat", lat, 2);
    chk("0,5 rho", int'(bus.rho_out), 5);
    chk("0,5 phi", int'(bus.phi_out), 0);
    pop();

    send(8'd5, 8'd0, 8'd2, 1'b0, lat);
    chk("5,0 rho", int'(bus.rho_out), 5);
    chk("5,0 phi", int'(bus.phi_out), 255);
    pop();

    send(8'd255, 8'd255, 8'd3, 1'b0, lat);
    chk("255 rho", int'(bus.rho_out), 255);
    chk("255 phi", int'(bus.phi_out), 127);
`ifdef CYL_SPH_SAT_FLAG_EN
    chk("255 sat", int'(bus.sat_flag), 1);
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp out_valid", int'(bus.out_valid), 1);
      chk("bp in_ready", int'(bus.in_ready), 0);
      chk("bp rho", int'(bus.rho_out), 255);
      chk("bp phi", int'(bus.phi_out), 127);
    end
    ena = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("ena0 hold", int'(bus.out_valid), 1);
    ena = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release", int'(bus.out_valid), 0);
`ifdef CYL_SPH_SAT_FLAG_EN
    chk("sat clr", int'(bus.sat_flag), 0);
`endif
    tick();
    chk("single hs", int'(bus.out_valid), 0);
    chk("idle ready", int'(bus.in_ready), 1);

    bus.in_valid = 1'b1;
    bus.r_in     = 8'd10;
    bus.z_in     = 8'd10;
    bus.theta_in = 8'd9;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", int'(bus.out_valid), 0);
    chk("mid rst rho", int'(bus.rho_out), 0);
    chk("mid rst phi", int'(bus.phi_out), 0);
    chk("mid rst theta", int'(bus.theta_out), 0);
    chk("mid rst in_ready", int'(bus.in_ready), 0);
    tick();
    tick();
    chk("in rst out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd3, 8'd4, 8'd11, 1'b0, lat);
    chk("after rst lat", lat, ITER + 2);
    chk("after rst rho", int'(bus.rho_out), 5);
    chk("after rst phi", int'(bus.phi_out), 105);
    chk("after rst theta", int'(bus.theta_out), 11);
    pop();

    send(8'd3, 8'd4, 8'h21, 1'b1, lat);
    chk("ena tog lat", lat, 2 * ITER + 2);
    chk("ena tog rho", int'(bus.rho_out), 5);
    chk("ena tog phi", int'(bus.phi_out), 105);
    pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
